// File: rtl/impix_switch_event_ctrl_if.sv
// Bus bundle between the switch event controller, the switch PIO (Avalon-MM slave)
// and the pixelization control path that consumes switch events.
interface impix_switch_event_ctrl_if #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 16
);
  logic [1:0]           pio_address;
  logic                 pio_chipselect;
  logic                 pio_write_n;
  logic [31:0]          pio_writedata;
  logic [31:0]          pio_readdata;
  logic                 pio_irq;
  logic                 evt_valid;
  logic                 evt_ready;
  logic [WIDTH-1:0]     evt_changed;
  logic [WIDTH-1:0]     evt_level;
  logic [CNT_WIDTH-1:0] evt_count;

  modport master (
    output pio_address, pio_chipselect, pio_write_n, pio_writedata,
    input  pio_readdata, pio_irq,
    output evt_valid, evt_changed, evt_level, evt_count,
    input  evt_ready
  );

  modport slave (
    input  pio_address, pio_chipselect, pio_write_n, pio_writedata,
    output pio_readdata, pio_irq,
    input  evt_valid, evt_changed, evt_level, evt_count,
    output evt_ready
  );
endinterface

// File: rtl/impix_switch_event_ctrl.sv
// Autonomous Avalon-MM master servicing the switch PIO: initialises the IRQ mask, reads and
// clears edge captures on each IRQ, and hands the result on as a valid/ready event with holdoff.
module impix_switch_event_ctrl #(
  parameter int          WIDTH          = 4,
  parameter logic [31:0] INIT_MASK      = 32'h0000_000F,
  parameter int          HOLDOFF_CYCLES = 50000,
  parameter int          CNT_WIDTH      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  impix_switch_event_ctrl_if.master   bus,
  output logic                        busy
);

  localparam logic [3:0] S_INIT_MASK_WR = 4'd0;
  localparam logic [3:0] S_INIT_CLR     = 4'd1;
  localparam logic [3:0] S_IDLE         = 4'd2;
  localparam logic [3:0] S_RD_CAP       = 4'd3;
  localparam logic [3:0] S_CAP_WAIT     = 4'd4;
  localparam logic [3:0] S_RD_DATA      = 4'd5;
  localparam logic [3:0] S_DATA_WAIT    = 4'd6;
  localparam logic [3:0] S_CLR          = 4'd7;
  localparam logic [3:0] S_EMIT         = 4'd8;
  localparam logic [3:0] S_HOLD         = 4'd9;

  localparam int              HOLD_W    = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = (HOLDOFF_CYCLES > 0) ? HOLD_W'(HOLDOFF_CYCLES - 1) : '0;

  logic [3:0]        state_r;
  logic [3:0]        state_s;
  logic [WIDTH-1:0]  cap_r;
  logic [WIDTH-1:0]  lvl_r;
  logic [HOLD_W-1:0] hold_r;
  logic              accept_s;
  logic              cs_s;
  logic              write_n_s;
  logic [1:0]        addr_s;
  logic [31:0]       wdata_s;

  assign accept_s = bus.evt_valid && bus.evt_ready;

  // Next-state logic for the PIO service sequence
  always_comb begin
    state_s = state_r;
    case (state_r)
      // Chipselect is low only in the first cycle after reset, so the mask write is held
      // for exactly one cycle on the bus before moving on.
      S_INIT_MASK_WR: begin
        if (bus.pio_chipselect) state_s = S_INIT_CLR;
        else                    state_s = S_INIT_MASK_WR;
      end
      S_INIT_CLR:  state_s = S_IDLE;
      S_IDLE: begin
        if (bus.pio_irq) state_s = S_RD_CAP;
        else             state_s = S_IDLE;
      end
      S_RD_CAP:    state_s = S_CAP_WAIT;
      S_CAP_WAIT: begin
        if (bus.pio_readdata[WIDTH-1:0] == '0) state_s = S_IDLE;
        else                                   state_s = S_RD_DATA;
      end
      S_RD_DATA:   state_s = S_DATA_WAIT;
      S_DATA_WAIT: state_s = S_CLR;
      S_CLR:       state_s = S_EMIT;
      S_EMIT: begin
        if (!accept_s)                state_s = S_EMIT;
        else if (HOLDOFF_CYCLES == 0) state_s = S_IDLE;
        else                          state_s = S_HOLD;
      end
      S_HOLD: begin
        if (hold_r == '0) state_s = S_IDLE;
        else              state_s = S_HOLD;
      end
      default:     state_s = S_INIT_MASK_WR;
    endcase
  end

  // Bus strobe decode of the upcoming state, registered so outputs track the state register
  always_comb begin
    cs_s      = 1'b0;
    write_n_s = 1'b1;
    addr_s    = 2'd0;
    wdata_s   = 32'h0000_0000;
    case (state_s)
      S_INIT_MASK_WR: begin
        cs_s = 1'b1; write_n_s = 1'b0; addr_s = 2'd2; wdata_s = INIT_MASK;
      end
      S_INIT_CLR: begin
        cs_s = 1'b1; write_n_s = 1'b0; addr_s = 2'd3; wdata_s = 32'hFFFF_FFFF;
      end
      S_RD_CAP: begin
        cs_s = 1'b1; write_n_s = 1'b1; addr_s = 2'd3;
      end
      S_RD_DATA: begin
        cs_s = 1'b1; write_n_s = 1'b1; addr_s = 2'd0;
      end
      S_CLR: begin
        cs_s = 1'b1; write_n_s = 1'b0; addr_s = 2'd3; wdata_s = 32'(cap_r);
      end
      default: begin
        cs_s = 1'b0; write_n_s = 1'b1; addr_s = 2'd0; wdata_s = 32'h0000_0000;
      end
    endcase
  end

  // State, bus outputs and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r            <= S_INIT_MASK_WR;
      bus.pio_chipselect <= 1'b0;
      bus.pio_write_n    <= 1'b1;
      bus.pio_address    <= 2'd0;
      bus.pio_writedata  <= 32'h0000_0000;
      bus.evt_valid      <= 1'b0;
      busy               <= 1'b1;
    end else begin
      state_r            <= state_s;
      bus.pio_chipselect <= cs_s;
      bus.pio_write_n    <= write_n_s;
      bus.pio_address    <= addr_s;
      bus.pio_writedata  <= wdata_s;
      bus.evt_valid      <= (state_s == S_EMIT);
      busy               <= (state_s != S_IDLE);
    end
  end

  // Capture/level latches from the PIO read-back and the published event payload
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_r           <= '0;
      lvl_r           <= '0;
      bus.evt_changed <= '0;
      bus.evt_level   <= '0;
    end else begin
      if (state_r == S_CAP_WAIT)  cap_r <= bus.pio_readdata[WIDTH-1:0];
      else                        cap_r <= cap_r;
      if (state_r == S_DATA_WAIT) lvl_r <= bus.pio_readdata[WIDTH-1:0];
      else                        lvl_r <= lvl_r;
      // Payload only moves when a new event is about to be presented
      if (state_r == S_CLR) begin
        bus.evt_changed <= cap_r;
        bus.evt_level   <= lvl_r;
      end else begin
        bus.evt_changed <= bus.evt_changed;
        bus.evt_level   <= bus.evt_level;
      end
    end
  end

  // Accepted-event counter and holdoff down-counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.evt_count <= '0;
      hold_r        <= '0;
    end else begin
      if (accept_s) begin
        bus.evt_count <= bus.evt_count + 1'b1;
        hold_r        <= HOLD_LOAD;
      end else if ((state_r == S_HOLD) && (hold_r != '0)) begin
        bus.evt_count <= bus.evt_count;
        hold_r        <= hold_r - 1'b1;
      end else begin
        bus.evt_count <= bus.evt_count;
        hold_r        <= hold_r;
      end
    end
  end

endmodule

// File: tb/tb_impix_switch_event_ctrl.sv
// Scoreboard bench: a behavioural switch PIO drives the main controller; expected bus writes
// and events are queued by the stimulus and popped by an independent monitor.
module tb_impix_switch_event_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  impix_switch_event_ctrl_if #(.WIDTH(4), .CNT_WIDTH(2))  bus1 ();
  impix_switch_event_ctrl_if #(.WIDTH(4), .CNT_WIDTH(16)) bus2 ();
  logic busy1, busy2;

  impix_switch_event_ctrl #(.WIDTH(4), .INIT_MASK(32'h0000_000F), .HOLDOFF_CYCLES(10), .CNT_WIDTH(2))
    u_dut1 (.clk(clk), .reset(rst), .bus(bus1.master), .busy(busy1));

  impix_switch_event_ctrl #(.WIDTH(4), .INIT_MASK(32'h0000_000F), .HOLDOFF_CYCLES(0), .CNT_WIDTH(16))
    u_dut2 (.clk(clk), .reset(rst), .bus(bus2.master), .busy(busy2));

  // Behavioural switch PIO for dut1: any-edge capture, write to address 3 clears all bits
  logic [3:0]  sw, sw_prev, edge_cap, irq_mask;
  logic [31:0] rd_q;
  logic        force_irq, rdy1, irq2;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_prev <= sw; edge_cap <= 4'h0; irq_mask <= 4'h0; rd_q <= 32'h0;
    end else begin
      sw_prev <= sw;
      if (bus1.pio_chipselect && !bus1.pio_write_n && bus1.pio_address == 2'd3)
        edge_cap <= sw ^ sw_prev;
      else
        edge_cap <= edge_cap | (sw ^ sw_prev);
      if (bus1.pio_chipselect && !bus1.pio_write_n && bus1.pio_address == 2'd2)
        irq_mask <= bus1.pio_writedata[3:0];
      if (bus1.pio_chipselect && bus1.pio_write_n) begin
        case (bus1.pio_address)
          2'd0:    rd_q <= {28'h0, sw};
          2'd2:    rd_q <= {28'h0, irq_mask};
          2'd3:    rd_q <= {28'h0, edge_cap};
          default: rd_q <= 32'h0;
        endcase
      end
    end
  end

  assign bus1.pio_readdata = rd_q;
  assign bus1.pio_irq      = (|(edge_cap & irq_mask)) | force_irq;
  assign bus1.evt_ready    = rdy1;
  assign bus2.pio_readdata = 32'h0000_0001;
  assign bus2.pio_irq      = irq2;
  assign bus2.evt_ready    = 1'b1;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, irq_cyc = 0, acc_cyc = 0, rdcap_cyc = 0, rdcap_n = 0;
  int wr_n = 0, ev_n = 0;

  typedef struct packed { logic [1:0] a; logic [31:0] d; } wr_t;
  typedef struct packed { logic [3:0] ch; logic [3:0] lv; logic [1:0] cnt; } evt_t;
  wr_t  wrq[$];
  evt_t evq[$];
  wr_t  w;
  evt_t e;
  logic       cnt_pend = 1'b0;
  logic [1:0] exp_cnt;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, want, $time);
  endtask

  // Cycle stamps of IRQ sampling in IDLE, handshakes and capture reads
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && bus1.pio_irq && !busy1) irq_cyc <= cyc;
    if (!rst && bus1.evt_valid && bus1.evt_ready) acc_cyc <= cyc;
    if (!rst && bus1.pio_chipselect && bus1.pio_write_n && bus1.pio_address == 2'd3) begin
      rdcap_cyc <= cyc;
      rdcap_n   <= rdcap_n + 1;
    end
  end

  // Monitor: pops expected writes/events whenever dut1 presents them
  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      if (cnt_pend) begin
        cnt_pend = 1'b0;
        chk("evt_count", 32'(bus1.evt_count), 32'(exp_cnt));
      end
      if (bus1.pio_chipselect && !bus1.pio_write_n) begin
        wr_n++;
        if (wrq.size() == 0) begin
          n_chk++;
          $display("FAIL wr_unexpected: got addr=%0d data=%h, expected no write", bus1.pio_address, bus1.pio_writedata);
        end else begin
          w = wrq.pop_front();
          chk("wr_addr", 32'(bus1.pio_address), 32'(w.a));
          chk("wr_data", bus1.pio_writedata, w.d);
        end
      end
      if (bus1.evt_valid && bus1.evt_ready) begin
        ev_n++;
        if (evq.size() == 0) begin
          n_chk++;
          $display("FAIL evt_unexpected: got changed=%h level=%h, expected no event", bus1.evt_changed, bus1.evt_level);
        end else begin
          e = evq.pop_front();
          chk("evt_changed", 32'(bus1.evt_changed), 32'(e.ch));
          chk("evt_level", 32'(bus1.evt_level), 32'(e.lv));
          exp_cnt  = e.cnt;
          cnt_pend = 1'b1;
        end
      end
    end
  end

  task automatic wait_evt(input string nm);
    logic ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus1.evt_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin n_chk++; $display("FAIL %s: got no evt_valid, expected one within 100 cycles", nm); end
  endtask

  task automatic wait_idle(input string nm);
    logic ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy1) begin ok = 1'b1; break; end
    end
    if (!ok) begin n_chk++; $display("FAIL %s: got busy=1, expected IDLE within 100 cycles", nm); end
  endtask

  initial begin
    int wr0, rc0, ev0, a2;
    logic ok;
    rst = 1'b1; sw = 4'h0; force_irq = 1'b0; rdy1 = 1'b1; irq2 = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_cs", 32'(bus1.pio_chipselect), 32'd0);
    chk("rst_write_n", 32'(bus1.pio_write_n), 32'd1);
    chk("rst_addr", 32'(bus1.pio_address), 32'd0);
    chk("rst_wdata", bus1.pio_writedata, 32'd0);
    chk("rst_valid", 32'(bus1.evt_valid), 32'd0);
    chk("rst_changed", 32'(bus1.evt_changed), 32'd0);
    chk("rst_level", 32'(bus1.evt_level), 32'd0);
    chk("rst_count", 32'(bus1.evt_count), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd1);

    // Init sequence: mask write then capture clear, one cycle each
    wrq.push_back('{a: 2'd2, d: 32'h0000_000F});
    wrq.push_back('{a: 2'd3, d: 32'hFFFF_FFFF});
    rst = 1'b0;
    @(negedge clk); chk("init_addr_mask", 32'(bus1.pio_address), 32'd2);
    @(negedge clk); chk("init_addr_clr", 32'(bus1.pio_address), 32'd3);
    @(negedge clk); chk("init_idle_busy", 32'(busy1), 32'd0);

    // Single edge on bit 1
    wrq.push_back('{a: 2'd3, d: 32'h0000_0002});
    evq.push_back('{ch: 4'b0010, lv: 4'b0010, cnt: 2'd1});
    sw = 4'b0010;
    wait_evt("single_evt");
    chk("latency", 32'(cyc - irq_cyc), 32'd6);
    wait_idle("single_idle");

    // Spurious IRQ with an empty capture register
    wr0 = wr_n; rc0 = rdcap_n; ev0 = ev_n;
    force_irq = 1'b1;
    @(negedge clk);
    force_irq = 1'b0;
    repeat (2) @(negedge clk);
    chk("spur_idle", 32'(busy1), 32'd0);
    chk("spur_rdcap", 32'(rdcap_n), 32'(rc0 + 1));
    repeat (3) @(negedge clk);
    chk("spur_no_write", 32'(wr_n), 32'(wr0));
    chk("spur_no_evt", 32'(ev_n), 32'(ev0));

    // Backpressure with a second edge arriving while the first event waits
    rdy1 = 1'b0;
    wrq.push_back('{a: 2'd3, d: 32'h0000_0001});
    evq.push_back('{ch: 4'b0001, lv: 4'b0011, cnt: 2'd2});
    sw = 4'b0011;
    wait_evt("bp_evt1");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus1.evt_valid), 32'd1);
      chk("bp_changed", 32'(bus1.evt_changed), 32'h1);
      chk("bp_level", 32'(bus1.evt_level), 32'h3);
      if (i == 5) begin
        wrq.push_back('{a: 2'd3, d: 32'h0000_0008});
        evq.push_back('{ch: 4'b1000, lv: 4'b1011, cnt: 2'd3});
        sw = 4'b1011;
      end
    end
    rdy1 = 1'b1;
    wait_evt("bp_evt2");
    chk("bp_holdoff", 32'(rdcap_cyc - acc_cyc), 32'd12);
    wait_idle("bp_idle");

    // Holdoff: edge re-arrives 3 cycles after accept; count wraps to 0 on this event
    wrq.push_back('{a: 2'd3, d: 32'h0000_0001});
    evq.push_back('{ch: 4'b0001, lv: 4'b1010, cnt: 2'd0});
    sw = 4'b1010;
    wait_evt("ho_evt1");
    repeat (3) @(negedge clk);
    wrq.push_back('{a: 2'd3, d: 32'h0000_0004});
    evq.push_back('{ch: 4'b0100, lv: 4'b1110, cnt: 2'd1});
    sw = 4'b1110;
    wait_evt("ho_evt2");
    chk("ho_holdoff", 32'(rdcap_cyc - acc_cyc), 32'd12);
    wait_idle("ho_idle");

    // Reset asserted while in CAP_WAIT
    sw = 4'b0110;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus1.pio_chipselect && bus1.pio_write_n && bus1.pio_address == 2'd3) begin ok = 1'b1; break; end
    end
    if (!ok) begin n_chk++; $display("FAIL mid_rdcap: got no capture read, expected one within 50 cycles"); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_cs", 32'(bus1.pio_chipselect), 32'd0);
    chk("mid_valid", 32'(bus1.evt_valid), 32'd0);
    chk("mid_count", 32'(bus1.evt_count), 32'd0);
    chk("mid_busy", 32'(busy1), 32'd1);
    wrq.push_back('{a: 2'd2, d: 32'h0000_000F});
    wrq.push_back('{a: 2'd3, d: 32'hFFFF_FFFF});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_idle("mid_reinit");
    repeat (3) @(negedge clk);

    // Zero holdoff: with IRQ held high the capture read follows accept via one IDLE cycle
    irq2 = 1'b1;
    ok = 1'b0; a2 = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus2.evt_valid) begin ok = 1'b1; a2 = cyc; break; end
    end
    if (!ok) begin n_chk++; $display("FAIL h0_evt: got no evt_valid, expected one within 50 cycles"); end
    else begin
      chk("h0_changed", 32'(bus2.evt_changed), 32'h1);
      chk("h0_level", 32'(bus2.evt_level), 32'h1);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus2.pio_chipselect && bus2.pio_write_n && bus2.pio_address == 2'd3) begin ok = 1'b1; break; end
      end
      if (!ok) begin n_chk++; $display("FAIL h0_rdcap: got no capture read, expected one within 20 cycles"); end
      else begin
        chk("h0_gap", 32'(cyc - a2), 32'd2);
        chk("h0_count", 32'(bus2.evt_count), 32'd1);
      end
    end
    irq2 = 1'b0;
    repeat (2) @(negedge clk);

    chk("wrq_empty", 32'(wrq.size()), 32'd0);
    chk("evq_empty", 32'(evq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
